// File: rtl/reset_sequencer.sv
// reset_sequencer
//
// Orders the DDR bring-up in the clk_sys domain. It pulses the MIG reset,
// then waits for calibration under a watchdog. If the watchdog expires it
// re-pulses the MIG reset, up to MAX_RETRIES times, and then gives up in
// FAIL. After calibration has been stable for POST_CALIB_DLY cycles it
// releases the application reset. If calibration drops while running, it
// puts the application back into reset and waits for calibration again.
//
// Ports:
//   clk_sys         in   system clock, sole clock of the block
//   rst_sys         in   synchronous active-high reset
//   mig_calib_done  in   MIG init_calib_complete, asynchronous to clk_sys
//   rst_mig         out  reset request to the MIG sys_rst input (active-high)
//   rst_app         out  synchronous active-high reset for application logic
//   ready           out  high only in RUN
//   fail            out  high only in FAIL
//   calib_lost      out  sticky, set when calibration drops while in RUN
//   retry_cnt       out  calibration retries consumed since rst_sys
//
// All outputs are registered. The output flops are decoded from the next
// state, so each output changes on the same edge as the state register.

module reset_sequencer #(
    parameter int MIG_RST_LEN    = 100,
    parameter int CALIB_TIMEOUT  = 2000000,
    parameter int MAX_RETRIES    = 3,
    parameter int POST_CALIB_DLY = 64,
    parameter int SYNC_STAGES    = 2,
    localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic            clk_sys,
    input  logic            rst_sys,
    input  logic            mig_calib_done,
    output logic            rst_mig,
    output logic            rst_app,
    output logic            ready,
    output logic            fail,
    output logic            calib_lost,
    output logic [RC_W-1:0] retry_cnt
);

    // The timer is shared by every timed state and sized for the longest one.
    localparam int T_MAX_A = (MIG_RST_LEN > CALIB_TIMEOUT) ? MIG_RST_LEN : CALIB_TIMEOUT;
    localparam int T_MAX   = (T_MAX_A > POST_CALIB_DLY) ? T_MAX_A : POST_CALIB_DLY;
    localparam int TMR_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TMR_W-1:0] MIG_LAST   = TMR_W'(MIG_RST_LEN - 1);
    localparam logic [TMR_W-1:0] CALIB_LAST = TMR_W'(CALIB_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] POST_LAST  = TMR_W'(POST_CALIB_DLY - 1);
    localparam logic [RC_W-1:0]  RETRY_MAX  = RC_W'(MAX_RETRIES);

    localparam logic [2:0] S_RESET      = 3'd0;
    localparam logic [2:0] S_MIG_RST    = 3'd1;
    localparam logic [2:0] S_WAIT_CALIB = 3'd2;
    localparam logic [2:0] S_POST_DLY   = 3'd3;
    localparam logic [2:0] S_RUN        = 3'd4;
    localparam logic [2:0] S_FAIL       = 3'd5;

    // Calibration status synchronizer. It is deliberately not reset, so a
    // calibration flag that is already high survives an rst_sys pulse.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   cal_s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], mig_calib_done};
    end

    always_ff @(posedge clk_sys) begin
        sync_q <= sync_d;
    end

    assign cal_s = sync_q[SYNC_STAGES-1];

    // Sequencer state
    logic [2:0]       state_q,   state_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [RC_W-1:0]  retry_q,   retry_d;
    logic             lost_q,    lost_d;
    logic             rst_mig_q, rst_mig_d;
    logic             rst_app_q, rst_app_d;
    logic             ready_q,   ready_d;
    logic             fail_q,    fail_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        case (state_q)
            S_RESET: begin
                state_d = S_MIG_RST;
                timer_d = '0;
            end
            S_MIG_RST: begin
                if (timer_q == MIG_LAST) begin
                    state_d = S_WAIT_CALIB;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_CALIB: begin
                // Calibration arriving on the last watchdog cycle still wins.
                if (cal_s) begin
                    state_d = S_POST_DLY;
                    timer_d = '0;
                end else if (timer_q == CALIB_LAST) begin
                    timer_d = '0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_MIG_RST;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_POST_DLY: begin
                // A calibration glitch is not counted as a retry.
                if (!cal_s) begin
                    state_d = S_WAIT_CALIB;
                    timer_d = '0;
                end else if (timer_q == POST_LAST) begin
                    state_d = S_RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!cal_s) begin
                    state_d = S_WAIT_CALIB;
                    timer_d = '0;
                    lost_d  = 1'b1;
                end
            end
            S_FAIL: begin
                // Terminal until rst_sys.
            end
            default: begin
                state_d = S_RESET;
                timer_d = '0;
            end
        endcase

        rst_mig_d = (state_d == S_RESET) || (state_d == S_MIG_RST);
        rst_app_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q   <= S_RESET;
            timer_q   <= '0;
            retry_q   <= '0;
            lost_q    <= 1'b0;
            rst_mig_q <= 1'b1;
            rst_app_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            rst_mig_q <= rst_mig_d;
            rst_app_q <= rst_app_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign rst_mig    = rst_mig_q;
    assign rst_app    = rst_app_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign calib_lost = lost_q;
    assign retry_cnt  = retry_q;

    // Output invariants
    a_ready_fail_excl: assert property (@(posedge clk_sys) disable iff (rst_sys)
        !(ready && fail));
    a_ready_app_free: assert property (@(posedge clk_sys) disable iff (rst_sys)
        ready |-> !rst_app);
    a_mig_holds_app: assert property (@(posedge clk_sys) disable iff (rst_sys)
        rst_mig |-> rst_app);

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the clock/reset generator in the clk_sys domain.
- Consumes the system reset and the MIG calibration status.
- Produces the ordered MIG reset request and the application-logic reset, plus ready/fail status.
- Watchdogs DDR calibration and retries it by re-pulsing the MIG reset; reasserts the application reset if calibration is lost while running.

Parameters:
MIG_RST_LEN, 100, clk_sys cycles rst_mig is held in the MIG_RST state (>=1)
CALIB_TIMEOUT, 2000000, clk_sys cycles allowed in WAIT_CALIB before a retry (>=1)
MAX_RETRIES, 3, calibration retries before FAIL (>=0)
POST_CALIB_DLY, 64, clk_sys cycles of stable calibration before rst_app releases (>=1)
SYNC_STAGES, 2, flip-flop stages in the mig_calib_done synchronizer (>=2)

Ports:
clk_sys  in  1  system clock; sole clock of the block
rst_sys  in  1  synchronous, active-high reset
mig_calib_done  in  1  MIG init_calib_complete; asynchronous to clk_sys
rst_mig  out  1  reset request to the MIG sys_rst input (active-high)
rst_app  out  1  synchronous active-high reset for application logic
ready  out  1  high only in RUN
fail  out  1  high only in FAIL
calib_lost  out  1  sticky; set when calibration drops while in RUN
retry_cnt  out  $clog2(MAX_RETRIES+1)  retries consumed so far

Behaviour:
- Reset is synchronous and active-high (rst_sys) on clk_sys. All outputs are registered.
- Values while rst_sys=1: state=RESET, rst_mig=1, rst_app=1, ready=0, fail=0, calib_lost=0, retry_cnt=0, timers=0.
- Synchronizer: mig_calib_done passes through SYNC_STAGES flops to give cal_s. The FSM acts on the edge after cal_s changes. The synchronizer flops are not reset.
- RESET: first edge with rst_sys=0 goes to MIG_RST, timer=0.
- MIG_RST: rst_mig=1, rst_app=1.
  - Timer counts to MIG_RST_LEN-1, then go to WAIT_CALIB with timer=0.
  - rst_mig is therefore high for exactly MIG_RST_LEN cycles after leaving RESET.
- WAIT_CALIB: rst_mig=0, rst_app=1, timer increments each cycle. cal_s=1 takes priority over timeout.
  - cal_s=1: go to POST_DLY, timer=0.
  - Otherwise, when timer==CALIB_TIMEOUT-1 and retry_cnt<MAX_RETRIES: retry_cnt+1, go to MIG_RST.
  - Otherwise, when timer==CALIB_TIMEOUT-1 and retry_cnt==MAX_RETRIES: go to FAIL.
- POST_DLY: rst_app=1.
  - cal_s=0: back to WAIT_CALIB, timer=0; retry_cnt unchanged.
  - Timer reaches POST_CALIB_DLY-1 with cal_s=1: go to RUN.
- RUN: rst_app=0, ready=1.
  - cal_s=0: on the next edge set rst_app=1, ready=0, calib_lost=1, and go to WAIT_CALIB with timer=0.
  - retry_cnt is not reset in RUN; watchdog retries stay cumulative until rst_sys.
- FAIL: rst_mig=0, rst_app=1, fail=1, ready=0. Terminal; exits only on rst_sys. A late cal_s=1 is ignored.
- rst_sys asserted in any state: on the next edge all state and outputs return to reset values, including sticky calib_lost and retry_cnt.
- Timer width: $clog2(max(MIG_RST_LEN, CALIB_TIMEOUT, POST_CALIB_DLY)). Counters never wrap; they are cleared on every state change.
- Invariants, checked by assertions:
  - ready and fail are never both 1.
  - ready=1 implies rst_app=0.
  - rst_mig=1 implies rst_app=1.

Test Plan (MIG_RST_LEN=4, CALIB_TIMEOUT=20, MAX_RETRIES=2, POST_CALIB_DLY=8, SYNC_STAGES=2):
1. Nominal: release rst_sys at cycle 0; raise calib_done at cycle 10 -> rst_mig high through cycle 4 only. rst_app falls and ready rises at cycle 10+2+1+8 (±1 per the documented edge). retry_cnt=0, fail=0.
2. One retry: calib_done held 0 -> rst_mig re-pulses 4 cycles after 20 WAIT_CALIB cycles and retry_cnt=1. Calib raised during the second window -> RUN, retry_cnt=1.
3. Exhaustion: calib_done never rises -> two retries (retry_cnt=2), then fail=1 after the third timeout. rst_app stays 1. A later calib_done=1 leaves fail=1.
4. Glitch in POST_DLY: calib_done high for 5 cycles then low -> back to WAIT_CALIB, ready never rises, retry_cnt unchanged. A second, stable rise -> RUN.
5. Loss in RUN: drop calib_done while ready=1 -> rst_app=1, ready=0 and calib_lost=1 within 2+1 cycles. Restoring calib -> RUN after 8 cycles, calib_lost still 1.
6. Mid-operation reset: assert rst_sys for 1 cycle in WAIT_CALIB with retry_cnt=1, and again in FAIL -> all outputs return to reset values on the next edge, then the sequence restarts from MIG_RST.
